// File: rtl/chan_mux_reg.sv
// Registered N-channel operand selector with fixed-select or round-robin grant
// and valid/ready handshakes on both the input channels and the output register.
module chan_mux_reg #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_q, rr_d;

  logic             can_load;
  logic             grant_valid;
  logic [SELW-1:0]  grant_ch;
  logic             fix_v, hi_v, lo_v;
  logic [SELW-1:0]  fix_ch, hi_ch, lo_ch;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  assign can_load = !out_valid_q || out_ready;

  // Round-robin: the lowest valid index above rr_q wins, otherwise wrap to the
  // lowest valid index at or below rr_q. Descending loops leave the lowest hit.
  always_comb begin
    fix_v = 1'b0;
    fix_ch = '0;
    hi_v = 1'b0;
    hi_ch = '0;
    lo_v = 1'b0;
    lo_ch = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (in_valid[i] && sel == SELW'(i)) begin
        fix_v = 1'b1;
        fix_ch = SELW'(i);
      end
      if (in_valid[i] && SELW'(i) > rr_q) begin
        hi_v = 1'b1;
        hi_ch = SELW'(i);
      end
      if (in_valid[i] && SELW'(i) <= rr_q) begin
        lo_v = 1'b1;
        lo_ch = SELW'(i);
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_ch = '0;
    if (!mode) begin
      grant_valid = fix_v;
      grant_ch = fix_ch;
    end else if (hi_v) begin
      grant_valid = 1'b1;
      grant_ch = hi_ch;
    end else begin
      grant_valid = lo_v;
      grant_ch = lo_ch;
    end
  end

  assign xfer = grant_valid && can_load && !rst;

  always_comb begin
    in_ready = '0;
    grant_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_ch == SELW'(i)) begin
        in_ready[i] = xfer;
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    out_ch_d = out_ch_q;
    out_valid_d = out_valid_q;
    rr_d = rr_q;
    if (xfer) begin
      out_data_d = grant_data;
      out_ch_d = grant_ch;
      out_valid_d = 1'b1;
      if (mode) rr_d = grant_ch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_ch_q <= '0;
      out_valid_q <= 1'b0;
      rr_q <= SELW'(CH - 1);
    end else begin
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_q <= rr_d;
    end
  end

  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_chan_mux_reg.sv
// Bench for chan_mux_reg: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_chan_mux_reg;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [1:0]     sel;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   ch_dat [N];

  int n_vec = 0;
  int n_err = 0;

  // model state: output word, its channel, and the last round-robin winner
  int m_valid = 0;
  int m_data = 0;
  int m_ch = 0;
  int m_rr = N - 1;

  chan_mux_reg #(.WIDTH(W), .CH(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = ch_dat[i];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Which channel the rules pick this cycle, or -1 for none.
  function automatic int pick();
    if (rst) return -1;
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      if (in_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  // Compare at the falling edge, then advance the model across the rising edge.
  task automatic step();
    int g;
    int exp_rdy;
    bit load;
    @(negedge clk);
    g = pick();
    load = (g >= 0) && (m_valid == 0 || out_ready);
    exp_rdy = load ? (1 << g) : 0;
    chk("in_ready", int'(in_ready), exp_rdy);
    chk("out_valid", int'(out_valid), m_valid);
    if (m_valid != 0) begin
      chk("out_data", int'(out_data), m_data);
      chk("out_ch", int'(out_ch), m_ch);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_rr = N - 1;
    end else if (load) begin
      m_valid = 1; m_data = int'(ch_dat[g]); m_ch = g;
      if (mode) m_rr = g;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_dat(input int a, input int b, input int c, input int d);
    ch_dat[0] = W'(a); ch_dat[1] = W'(b); ch_dat[2] = W'(c); ch_dat[3] = W'(d);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    set_dat(8'h10, 8'h20, 8'h30, 8'h40);
    @(posedge clk); #1;

    // reset held two cycles with every channel valid
    step(); step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_ready", int'(in_ready), 0);
    rst = 1'b0; #1;
    chk("rr_first_rdy", int'(in_ready), 4'b0001);
    step();
    chk("rr_first_ch", int'(out_ch), 0);

    // fixed select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_dat(0, 0, 8'hA5, 0); #1;
    chk("fix_rdy", int'(in_ready), 4'b0100);
    step();
    chk("fix_data", int'(out_data), 8'hA5);
    chk("fix_ch", int'(out_ch), 2);
    chk("fix_valid", int'(out_valid), 1);
    sel = 2'd3; in_valid = 4'b0000; #1;
    chk("fix_nogrant", int'(in_ready), 0);
    step();
    chk("fix_drain", int'(out_valid), 0);

    // backpressure
    sel = 2'd0; in_valid = 4'b0001; set_dat(8'h11, 0, 0, 0); out_ready = 1'b0;
    step();
    chk("bp_load", int'(out_data), 8'h11);
    for (int i = 0; i < 3; i++) begin
      sel = 2'($urandom); in_valid = 4'($urandom) | 4'b0001;
      set_dat($urandom, $urandom, $urandom, $urandom); #1;
      chk("bp_rdy", int'(in_ready), 0);
      step();
      chk("bp_hold", int'(out_data), 8'h11);
    end
    out_ready = 1'b1; sel = 2'd1; in_valid = 4'b0010; set_dat(0, 8'h22, 0, 0);
    step();
    chk("bp_reload", int'(out_data), 8'h22);
    chk("bp_valid", int'(out_valid), 1);

    // round-robin rotation from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    mode = 1'b1; in_valid = 4'hF; set_dat(8'h10, 8'h20, 8'h30, 8'h40);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_seq_ch", int'(out_ch), i % 4);
      chk("rr_seq_data", int'(out_data), ((i % 4) + 1) * 16);
    end
    in_valid = 4'b1010;
    step();
    chk("rr_pair1", int'(out_ch), 1);
    step();
    chk("rr_pair3", int'(out_ch), 3);

    // mode switch keeps the pointer
    in_valid = 4'b0100;
    step();
    chk("ms_rr2", int'(out_ch), 2);
    mode = 1'b0; sel = 2'd0; in_valid = 4'hF;
    step(); step();
    chk("ms_fix0", int'(out_ch), 0);
    mode = 1'b1;
    step();
    chk("ms_rr3", int'(out_ch), 3);

    // reset wins over a transfer
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; set_dat(0, 8'h77, 0, 0); rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 4'b0000;
    chk("mid_rst_valid", int'(out_valid), 0);
    step();
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_valid2", int'(out_valid), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      sel = 2'($urandom);
      in_valid = 4'($urandom);
      set_dat($urandom, $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/chan_mux_reg.md
# chan_mux_reg

Parametrised, registered N-channel operand selector for the arithmetic unit: the pipelined successor of the fixed 8-bit two-input operand mux. It chooses one of CH WIDTH-bit source channels, either by an explicit select or by round-robin arbitration, and captures the winner into an output register. Valid/ready handshakes on both sides let it sit between operand sources and the ALU input stage without losing or duplicating data.

## Interface
- WIDTH, 8, data width per channel, ≥1
- CH, 4, number of input channels, ≥2
- SELW, $clog2(CH), width of the select and channel-index fields
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CH  per-channel data-valid
- in_ready  output  CH  per-channel accept; at most one bit high
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in fixed mode
- out_data  output  WIDTH  registered selected data
- out_ch  output  SELW  index of the channel that out_data came from
- out_valid  output  1  output register holds data
- out_ready  input  1  downstream accepts the data

## Operation
- The block has one clock and a synchronous, active-high reset (`rst`) sampled on the rising edge of `clk`.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=CH-1, in_ready=0 during the reset cycle.
- can_load = !out_valid | out_ready.
- Grant selection, combinational each cycle:
  - Fixed mode (mode=0): candidate = sel. Grant only if sel < CH and in_valid[sel]=1. An out-of-range sel (CH not a power of 2) gives no grant.
  - Round-robin mode (mode=1): scan channels rr_ptr+1, rr_ptr+2, … modulo CH. Grant the first channel with in_valid=1. No valid channel gives no grant.
- in_ready[g] = can_load & grant_valid for the granted channel g; every other bit is 0. A transfer happens on channel g when in_valid[g] & in_ready[g].
- On a transfer: out_data ← channel g data, out_ch ← g, out_valid ← 1.
- In round-robin mode only, a transfer also sets rr_ptr ← g. Fixed mode never changes rr_ptr.
- Downstream accept without a new transfer (out_valid & out_ready & no grant): out_valid ← 0. out_data and out_ch hold their last values.
- No downstream accept while out_valid=1: out_data, out_ch, out_valid hold, all in_ready=0, and changes on sel, mode or inputs have no effect on the held word.
- A change of mode takes effect on the next cycle's grant. rr_ptr is kept across mode changes.
- The block never drops or duplicates data: each accepted input word appears exactly once on out_data with out_valid=1.

## Timing
- Latency: 1 cycle from an input transfer edge to out_valid/out_data.
- Throughput: 1 word per cycle when out_ready is held at 1 (load and drain happen on the same edge).
- in_ready depends combinationally on in_valid, sel, mode, out_valid, out_ready and rr_ptr. It has no combinational path from in_data.
- out_* are driven directly from registers.
- rst asserted in the middle of a transfer wins: the next state is the reset state and the input word is discarded. The source sees in_ready=0 during reset.
- Round-robin fairness: if all CH channels stay valid, grants rotate 0,1,…,CH-1,0 with no channel granted twice within any CH consecutive transfers.

## Test plan
- Reset: drive rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release in mode=1, the first grant is ch0.
- Fixed mode, WIDTH=8, CH=4: sel=2, in_valid=4'b0100, ch2 data=0xA5, out_ready=1 -> in_ready=4'b0100. The next cycle gives out_data=0xA5, out_ch=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> no grant, and out_valid falls after the drain.
- Backpressure: out_valid=1 holding 0x11 with out_ready=0 for 3 cycles while sel and the inputs change -> out_data stays 0x11, in_ready=0. Raise out_ready=1 with ch1 valid carrying 0x22 -> the same edge drains 0x11 and loads 0x22.
- Round-robin: all four channels valid with data 0x10,0x20,0x30,0x40, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Then with only ch1 and ch3 valid after a ch1 grant -> next grant is ch3.
- Mode switch: after a round-robin grant of ch2, set mode=0, sel=0 for 2 transfers, then mode=1 -> the first round-robin grant is ch3, since rr_ptr was kept at 2.
- Reset mid-stream: assert rst on an edge where a transfer of 0x77 would occur -> 0x77 never appears, out_valid=0 the cycle after.
